// File: rtl/imem_pkg.sv
// Shared types and default sizing for the loadable instruction memory.
package imem_pkg;

    localparam int DEPTH_DEF      = 64;
    localparam int PC_W_DEF       = 16;
    localparam int INST_BYTES_DEF = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_e;

endpackage

// File: rtl/imem_bank.sv
// Byte-wide instruction storage: one synchronous write port and RD_PORTS
// combinational read ports so a whole instruction word is read in one cycle.
module imem_bank
    import imem_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int RD_PORTS = INST_BYTES_DEF,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [AW-1:0]                waddr_i,
    input  logic [7:0]                   wdata_i,
    input  logic [RD_PORTS-1:0][AW-1:0]  raddr_i,
    output logic [RD_PORTS-1:0][7:0]     rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // NOTE: the array is deliberately not reset; the controller never exposes
    // a byte that was not written by the current load, and a reset net into
    // every storage bit would block mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        for (int i = 0; i < RD_PORTS; i++) begin
            rdata_o[i] = mem_q[raddr_i[i]];
        end
    end

endmodule

// File: rtl/imem_prog.sv
// Program-loadable instruction memory: a byte stream fills the bank, then
// fixed-width big-endian fetches with a one-cycle latency and a range fault.
module imem_prog
    import imem_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int PC_W       = PC_W_DEF,
    parameter int INST_BYTES = INST_BYTES_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_start,
    input  logic                    ld_valid,
    input  logic [7:0]              ld_data,
    input  logic                    ld_last,
    output logic                    ld_ready,
    input  logic                    fetch_req,
    input  logic [PC_W-1:0]         pc,
    output logic [8*INST_BYTES-1:0] inst,
    output logic                    inst_valid,
    output logic                    fault,
    output logic                    imem_ready,
    output logic [PC_W:0]           prog_len
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int PLW = PC_W + 1;
    localparam int IW  = 8 * INST_BYTES;

    state_e                           state_q, state_d;
    logic [CW-1:0]                    wcnt_q, wcnt_d;
    logic [PLW-1:0]                   prog_len_q, prog_len_d;
    logic [IW-1:0]                    inst_q, inst_d;
    logic                             inst_valid_q, inst_valid_d;
    logic                             fault_q, fault_d;

    logic                             ld_accept;
    logic [CW-1:0]                    wcnt_inc;
    logic                             fetch_accept;
    logic [PLW-1:0]                   fetch_end;
    logic                             range_fault;
    logic [INST_BYTES-1:0][AW-1:0]    raddr;
    logic [INST_BYTES-1:0][7:0]       rdata;
    logic [IW-1:0]                    word;

    assign ld_ready  = (state_q == LOAD) && !ld_start;
    assign ld_accept = ld_valid && ld_ready;
    assign wcnt_inc  = wcnt_q + 1'b1;

    imem_bank #(
        .DEPTH    (DEPTH),
        .RD_PORTS (INST_BYTES)
    ) u_bank (
        .clk     (clk),
        .we_i    (ld_accept),
        .waddr_i (wcnt_q[AW-1:0]),
        .wdata_i (ld_data),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        prog_len_d = prog_len_q;
        unique case (state_q)
            EMPTY: begin
                if (ld_start) begin
                    state_d = LOAD;
                    wcnt_d  = '0;
                end
            end
            LOAD: begin
                if (ld_start) begin
                    wcnt_d = '0;
                end else if (ld_accept) begin
                    wcnt_d = wcnt_inc;
                    if (ld_last || (wcnt_inc == CW'(DEPTH))) begin
                        state_d    = READY;
                        prog_len_d = PLW'(wcnt_inc);
                    end
                end
            end
            READY: begin
                if (ld_start) begin
                    state_d    = LOAD;
                    wcnt_d     = '0;
                    prog_len_d = '0;
                end
            end
            default: begin
                state_d = EMPTY;
                wcnt_d  = '0;
            end
        endcase
    end

    // A fetch racing a new load is dropped: the memory is about to be rewritten.
    assign fetch_accept = fetch_req && (state_q == READY) && !ld_start;
    assign fetch_end    = {1'b0, pc} + PLW'(INST_BYTES);
    assign range_fault  = fetch_end > prog_len_q;

    always_comb begin
        word = '0;
        for (int i = 0; i < INST_BYTES; i++) begin
            raddr[i]                         = pc[AW-1:0] + AW'(i);
            word[8*(INST_BYTES-1-i) +: 8]    = rdata[i];
        end
    end

    always_comb begin
        inst_d       = inst_q;
        fault_d      = fault_q;
        inst_valid_d = fetch_accept;
        if (fetch_accept) begin
            fault_d = range_fault;
            inst_d  = range_fault ? '0 : word;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= EMPTY;
            wcnt_q       <= '0;
            prog_len_q   <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            prog_len_q   <= prog_len_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign fault      = fault_q;
    assign imem_ready = (state_q == READY);
    assign prog_len   = prog_len_q;

endmodule

// File: doc/imem_prog.md
IMEM_PROG -- requirements
Module: imem_prog

Interface
REQ-001 SHALL provide parameter DEPTH, default 64, instruction-memory size in bytes (power of 2, 4..65536).
REQ-002 SHALL provide parameter PC_W, default 16, program-counter width in bits.
REQ-003 SHALL provide parameter INST_BYTES, default 2, bytes returned per fetch (1..4).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ld_start  input  1  pulse: begin a new program load.
REQ-007 SHALL have ports ld_valid/ld_data/ld_last  input  1/8/1  load byte stream, qualified by ld_valid.
REQ-008 SHALL have port ld_ready  output  1  load byte accepted when ld_valid&&ld_ready.
REQ-009 SHALL have ports fetch_req/pc  input  1/PC_W  fetch request and byte address.
REQ-010 SHALL have ports inst/inst_valid/fault  output  8*INST_BYTES/1/1  fetched word, result strobe, range fault.
REQ-011 SHALL have ports imem_ready/prog_len  output  1/PC_W+1  program loaded; loaded byte count.

Function
REQ-012 SHALL implement FSM states EMPTY, LOAD, READY.
REQ-013 SHALL transition EMPTY->LOAD and READY->LOAD on ld_start; ld_start in LOAD restarts the load.
REQ-014 SHALL clear write counter wcnt to 0 on entry to LOAD, including restart.
REQ-015 SHALL drive ld_ready = (state==LOAD) && !ld_start, combinationally.
REQ-016 SHALL write ld_data to mem[wcnt] and increment wcnt on each accepted byte.
REQ-017 SHALL go LOAD->READY in the cycle after the accepted byte carrying ld_last or the byte that makes wcnt==DEPTH; prog_len = final wcnt.
REQ-018 SHALL ignore ld_valid outside LOAD; no write, no count change.
REQ-019 SHALL drive imem_ready = (state==READY).
REQ-020 SHALL accept fetch_req only in READY; fetch_req in EMPTY/LOAD produces no inst_valid.
REQ-021 SHALL return fetch result with 1-cycle latency: inst_valid high exactly one cycle after an accepted fetch_req.
REQ-022 SHALL order inst big-endian: inst[MSB byte]=mem[pc], next byte mem[pc+1], through mem[pc+INST_BYTES-1].
REQ-023 SHALL assert fault with inst_valid, and force inst=0, when pc+INST_BYTES > prog_len, computed at PC_W+1 bits (no address wrap).
REQ-024 SHALL support back-to-back fetches, one per cycle, with no bubble.
REQ-025 SHALL hold inst and fault at last value while inst_valid is low.
REQ-026 SHALL drop an accepted fetch in flight when ld_start arrives in the same cycle (inst_valid low next cycle), since memory is about to change.

Reset
REQ-027 SHALL, on rst low, asynchronously force state=EMPTY, wcnt=0, prog_len=0, inst=0, inst_valid=0, fault=0.
REQ-028 SHALL leave memory array contents unspecified after reset; no read before a completed load is observable.
REQ-029 SHALL abandon a load in progress on reset; a fresh ld_start is required afterwards.

Structure
REQ-030 SHALL place the state enum and the default DEPTH/PC_W/INST_BYTES values in the shared package imem_pkg.
REQ-031 SHALL isolate storage in sub-module imem_bank: one byte write port, INST_BYTES combinational byte read ports.
REQ-032 SHALL keep FSM, counters, fault compare and output registers in imem_prog.

Verification
REQ-033 SHALL test: reset, ld_start, load bytes 01 2F 01 2E (last on 2E), fetch pc=0 then pc=2 -> inst=012F then 012E, fault=0, prog_len=4.
REQ-034 SHALL test: after REQ-033 load, fetch pc=3 -> inst_valid=1, fault=1, inst=0000; fetch pc=0xFFFF -> fault=1, no wrap.
REQ-035 SHALL test: DEPTH=64, stream 64 bytes without ld_last -> READY after byte 64, prog_len=64, ld_ready low thereafter.
REQ-036 SHALL test: fetch_req in EMPTY and during LOAD -> no inst_valid; ld_start with ld_valid same cycle -> byte not written, wcnt=0.
REQ-037 SHALL test: rst low mid-load after 3 bytes -> state EMPTY, imem_ready=0, prog_len=0, outputs cleared immediately (asynchronous).
REQ-038 SHALL test: INST_BYTES=4, load 8 bytes 00..07, fetches pc=0,4 on consecutive cycles -> 00010203, 04050607 on consecutive cycles.
